// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program-memory arbiter.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        DRAIN  = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

    typedef enum logic {
        ID_CPU = 1'b0,
        ID_DBG = 1'b1
    } req_id_t;

    // Cycles from memory command to mem_rdata valid.
    localparam int MEM_RD_LAT = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the fetch unit, bit 1 the debug port.
module rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 0 = bit 0 wins a tie, 1 = bit 1 wins a tie
    logic rr_ptr;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= 1'b0;
        end else if (advance && (|gnt)) begin
            rr_ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/prog_mem_arbiter.sv
// Single-port program memory arbiter: loader > {fetch, debug round-robin},
// registered memory command, tagged fixed-latency read return, loader lock mode.
//
//   state  | meaning
//   NORMAL | loader has priority, fetch/debug share round-robin
//   DRAIN  | lock requested; no grants until outstanding reads return
//   LOCKED | loader owns the memory exclusively
module prog_mem_arbiter
    import prog_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  ld_lock,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [7:0]            ld_wdata,
    output logic                  ld_gnt,

    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [7:0]            cpu_rdata,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [7:0]            dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [7:0]            dbg_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,

    output logic                  locked
);

    // Stage 0 rides with the mem command, the last stage with mem_rdata.
    localparam int TAG_STAGES = 1 + MEM_RD_LAT;

    arb_state_t            state;
    logic [1:0]            rr_req;
    logic [1:0]            rr_gnt;
    logic [TAG_STAGES-1:0] tag_vld;
    req_id_t               tag_id [TAG_STAGES];
    logic                  pipe_empty;
    logic                  rd_accept;

    always_comb begin
        ld_gnt = 1'b0;
        rr_req = 2'b00;
        if (resetn) begin
            case (state)
                NORMAL: begin
                    ld_gnt = ld_req;
                    rr_req = (ld_req || ld_lock) ? 2'b00 : {dbg_req, cpu_req};
                end
                LOCKED:  ld_gnt = ld_req;
                default: ld_gnt = 1'b0;
            endcase
        end
    end

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .resetn  (resetn),
        .req     (rr_req),
        .advance (|rr_gnt),
        .gnt     (rr_gnt)
    );

    assign cpu_gnt    = rr_gnt[0];
    assign dbg_gnt    = rr_gnt[1];
    assign rd_accept  = cpu_gnt || (dbg_gnt && !dbg_we);
    assign pipe_empty = ~|tag_vld;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= NORMAL;
            locked <= 1'b0;
        end else begin
            case (state)
                NORMAL: begin
                    if (ld_lock) state <= DRAIN;
                end
                DRAIN: begin
                    if (!ld_lock) begin
                        state <= NORMAL;
                    end else if (pipe_empty) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!ld_lock) begin
                        state  <= NORMAL;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= NORMAL;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
        end else begin
            mem_en <= ld_gnt || cpu_gnt || dbg_gnt;
            mem_we <= 1'b0;
            if (ld_gnt) begin
                mem_we    <= 1'b1;
                mem_addr  <= ld_addr;
                mem_wdata <= ld_wdata;
            end else if (cpu_gnt) begin
                mem_addr  <= cpu_addr;
            end else if (dbg_gnt) begin
                mem_we    <= dbg_we;
                mem_addr  <= dbg_addr;
                mem_wdata <= dbg_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_vld <= '0;
            for (int i = 0; i < TAG_STAGES; i++) tag_id[i] <= ID_CPU;
        end else begin
            tag_vld   <= {tag_vld[TAG_STAGES-2:0], rd_accept};
            tag_id[0] <= cpu_gnt ? ID_CPU : ID_DBG;
            for (int i = 1; i < TAG_STAGES; i++) tag_id[i] <= tag_id[i-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= 8'h00;
            dbg_rdata  <= 8'h00;
        end else begin
            cpu_rvalid <= tag_vld[TAG_STAGES-1] && (tag_id[TAG_STAGES-1] == ID_CPU);
            dbg_rvalid <= tag_vld[TAG_STAGES-1] && (tag_id[TAG_STAGES-1] == ID_DBG);
            if (tag_vld[TAG_STAGES-1]) begin
                cpu_rdata <= mem_rdata;
                dbg_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter with a behavioural single-port memory.
module tb_prog_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ld_lock, ld_req;
    logic [11:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic        ld_gnt;
    logic        cpu_req;
    logic [11:0] cpu_addr;
    logic        cpu_gnt, cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        dbg_req, dbg_we;
    logic [11:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [7:0]  dbg_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        locked;

    logic [7:0]  mem [4096];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prog_mem_arbiter #(.ADDR_WIDTH(12)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ld_lock    (ld_lock),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_gnt     (ld_gnt),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .locked     (locked)
    );

    // Synchronous single-port memory: read data valid the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        ld_lock = 1'b0; ld_req = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[5] = 8'hAB;
        mem[6] = 8'hCD;
        ld_addr = 12'h000; ld_wdata = 8'h00; cpu_addr = 12'h000;
        dbg_addr = 12'h000; dbg_wdata = 8'h00;

        // Reset with every request asserted
        resetn = 1'b0;
        ld_lock = 1'b0; ld_req = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0;
        next(); next(); #1;
        check("rst_ld_gnt", ld_gnt, 0);
        check("rst_cpu_gnt", cpu_gnt, 0);
        check("rst_dbg_gnt", dbg_gnt, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_dbg_rvalid", dbg_rvalid, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_locked", locked, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        clear_reqs();
        next(); resetn = 1'b1;

        // Single fetch read of 0x005
        next(); cpu_req = 1'b1; cpu_addr = 12'h005; #1;
        check("rd_cpu_gnt_T", cpu_gnt, 1);
        next(); cpu_req = 1'b0; #1;
        check("rd_mem_en_T1", mem_en, 1);
        check("rd_mem_we_T1", mem_we, 0);
        check("rd_mem_addr_T1", mem_addr, 12'h005);
        next(); #1;
        check("rd_rvalid_T2", cpu_rvalid, 0);
        next(); #1;
        check("rd_cpu_rvalid_T3", cpu_rvalid, 1);
        check("rd_cpu_rdata_T3", cpu_rdata, 8'hAB);
        check("rd_dbg_rvalid_T3", dbg_rvalid, 0);
        next(); #1;
        check("rd_cpu_rvalid_T4", cpu_rvalid, 0);

        // Fresh reset so the round-robin pointer starts at cpu
        resetn = 1'b0; next(); resetn = 1'b1;

        // Priority: loader wins for 5 cycles, then cpu/dbg alternate
        next();
        ld_req = 1'b1; ld_addr = 12'h100; ld_wdata = 8'h55;
        cpu_req = 1'b1; cpu_addr = 12'h010; dbg_req = 1'b1; dbg_addr = 12'h020;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("pri_ld_gnt", ld_gnt, 1);
            check("pri_cpu_gnt", cpu_gnt, 0);
            check("pri_dbg_gnt", dbg_gnt, 0);
            next();
        end
        ld_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_cpu_gnt", cpu_gnt, (i % 2 == 0) ? 1 : 0);
            check("rr_dbg_gnt", dbg_gnt, (i % 2 == 1) ? 1 : 0);
            next();
        end
        clear_reqs();
        next(); next(); next(); next();

        // Lock with two fetch reads outstanding
        cpu_req = 1'b1; cpu_addr = 12'h005; #1;
        check("lk_cpu_gnt_T", cpu_gnt, 1);
        next(); cpu_addr = 12'h006; #1;
        check("lk_cpu_gnt_T1", cpu_gnt, 1);
        next(); ld_lock = 1'b1; #1;
        check("lk_cpu_gnt_forced", cpu_gnt, 0);
        check("lk_locked_T2", locked, 0);
        next(); ld_req = 1'b1; ld_addr = 12'h200; ld_wdata = 8'h11; #1;
        check("lk_rvalid1", cpu_rvalid, 1);
        check("lk_rdata1", cpu_rdata, 8'hAB);
        check("lk_drain_ld_gnt1", ld_gnt, 0);
        check("lk_drain_cpu_gnt1", cpu_gnt, 0);
        check("lk_locked_T3", locked, 0);
        next(); #1;
        check("lk_rvalid2", cpu_rvalid, 1);
        check("lk_rdata2", cpu_rdata, 8'hCD);
        check("lk_drain_ld_gnt2", ld_gnt, 0);
        check("lk_locked_T4", locked, 0);
        next(); #1;
        check("lk_rvalid_done", cpu_rvalid, 0);
        check("lk_locked_T5", locked, 1);
        check("lk_ld_gnt_locked", ld_gnt, 1);
        check("lk_cpu_gnt_locked", cpu_gnt, 0);
        next(); ld_req = 1'b0; #1;
        check("lk_locked_T6", locked, 1);
        check("lk_cpu_gnt_T6", cpu_gnt, 0);
        cpu_req = 1'b0;

        // Loader burst of 0x2B to addresses 0..3
        next();
        ld_req = 1'b1; ld_wdata = 8'h2B;
        for (int i = 0; i < 4; i++) begin
            ld_addr = 12'(i); #1;
            check("bu_ld_gnt", ld_gnt, 1);
            if (i > 0) begin
                check("bu_mem_en", mem_en, 1);
                check("bu_mem_we", mem_we, 1);
                check("bu_mem_addr", mem_addr, i - 1);
            end
            next();
        end
        ld_req = 1'b0; #1;
        check("bu_mem_en_last", mem_en, 1);
        check("bu_mem_we_last", mem_we, 1);
        check("bu_mem_addr_last", mem_addr, 3);
        check("bu_mem_wdata_last", mem_wdata, 8'h2B);
        next(); ld_lock = 1'b0; #1;
        check("bu_mem_en_idle", mem_en, 0);
        check("ul_locked_hold", locked, 1);
        next(); #1;
        check("ul_locked_fall", locked, 0);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h002; #1;
        check("ul_dbg_gnt", dbg_gnt, 1);
        next(); dbg_req = 1'b0;
        next(); next(); #1;
        check("ul_dbg_rvalid", dbg_rvalid, 1);
        check("ul_dbg_rdata", dbg_rdata, 8'h2B);
        check("ul_cpu_rvalid", cpu_rvalid, 0);
        next(); next();

        // Abort: ld_lock drops while still draining
        cpu_req = 1'b1; cpu_addr = 12'h005; #1;
        check("ab_cpu_gnt_A", cpu_gnt, 1);
        next(); ld_lock = 1'b1; #1;
        check("ab_cpu_gnt_A1", cpu_gnt, 0);
        next(); #1;
        check("ab_cpu_gnt_drain", cpu_gnt, 0);
        check("ab_locked_A2", locked, 0);
        next(); ld_lock = 1'b0; #1;
        check("ab_cpu_gnt_A3", cpu_gnt, 0);
        check("ab_locked_A3", locked, 0);
        check("ab_rvalid_A3", cpu_rvalid, 1);
        next(); #1;
        check("ab_cpu_gnt_normal", cpu_gnt, 1);
        check("ab_locked_A4", locked, 0);

        // Reset with that read in flight
        next(); cpu_req = 1'b0; resetn = 1'b0; #1;
        check("rr_mem_en_rst", mem_en, 0);
        next(); resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next(); #1;
            check("rr_cpu_rvalid", cpu_rvalid, 0);
            check("rr_dbg_rvalid", dbg_rvalid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prog_mem_arbiter.md
# prog_mem_arbiter

Shares the single-port program memory among three requesters: the program loader (writes), the CPU instruction-fetch unit (reads), and the host debug port (reads and writes). The block sits between those requesters and the program BRAM/SRAM. It grants at most one access per cycle and registers the memory command. It returns read data to the originating requester with a fixed latency. It also provides a lock mode, so a loader burst runs with fetch and debug stalled.

## Interface
- ADDR_WIDTH, 12, program memory address width
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- ld_lock  in  1  loader requests exclusive ownership
- ld_req / ld_addr / ld_wdata  in  1 / ADDR_WIDTH / 8  loader write request
- ld_gnt  out  1  loader request accepted this cycle
- cpu_req / cpu_addr  in  1 / ADDR_WIDTH  fetch read request
- cpu_gnt  out  1  fetch accepted this cycle
- cpu_rvalid / cpu_rdata  out  1 / 8  fetch read return
- dbg_req / dbg_we / dbg_addr / dbg_wdata  in  1 / 1 / ADDR_WIDTH / 8  debug access
- dbg_gnt  out  1  debug accepted this cycle
- dbg_rvalid / dbg_rdata  out  1 / 8  debug read return
- mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / ADDR_WIDTH / 8  memory command, registered
- mem_rdata  in  8  memory read data, valid 1 cycle after mem_en & !mem_we
- locked  out  1  high while in LOCKED state

## Operation
- Handshake: a transfer is accepted in any cycle where req & gnt. Requesters hold req and the payload stable until gnt. gnt is combinational from the current req, state and rr_ptr.
- States: NORMAL, DRAIN, LOCKED.
  - NORMAL: fixed priority loader > {cpu, dbg}. cpu and dbg share by round-robin. rr_ptr (0 = cpu first, 1 = dbg first) flips to favour the other requester after each cpu or dbg grant. Loader grants do not move rr_ptr. ld_lock high → DRAIN. cpu_gnt and dbg_gnt are forced low in the same cycle ld_lock is high.
  - DRAIN: no grants of any kind. Stay until the read-return pipeline is empty (both tag stages invalid), then go to LOCKED.
  - LOCKED: only ld_req can be granted, and ld_gnt = ld_req. ld_lock low → NORMAL. The first cpu or dbg grant is possible in the cycle after the state returns to NORMAL.
- Accepted command: registered into mem_* on the next edge. mem_en is high for exactly one cycle per accepted transfer.
- Read tag pipeline: stage 1 holds {valid, id} with the mem command. Stage 2 holds {valid, id} when mem_rdata is valid. The id is cpu or dbg.
- Read return: cpu_rdata and dbg_rdata are both driven from mem_rdata, registered. Only the rvalid of the tagged requester pulses.
- Writes generate no rvalid.
- Any state other than the three above → NORMAL.

## Timing
- Reset values: all gnt 0, all rvalid 0, rdata 8'h00, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, locked 0, rr_ptr 0, state NORMAL, tag pipeline invalid.
- Latencies, counted from the accept edge T:
  - mem_en at T+1.
  - mem_rdata at T+2.
  - rvalid and rdata at T+3.
- Sustained throughput is 1 access per cycle, fully pipelined.
- locked rises on the edge that enters LOCKED. It falls on the edge that leaves LOCKED.
- ld_lock deasserted while in DRAIN → back to NORMAL, with no lock taken.
- Reset mid-burst: outstanding reads are discarded and no rvalid is produced after reset.
- ld_req while in DRAIN: not granted until LOCKED.

## Structure
- Shared package prog_mem_pkg: arb_state_t (NORMAL, DRAIN, LOCKED), req_id_t (ID_CPU, ID_DBG), and the read-latency constant MEM_RD_LAT = 1.
- One sub-module: rr_arb2, the two-way round-robin arbiter holding rr_ptr, with inputs req[1:0] and advance, and output gnt[1:0].
- The FSM, tag pipeline and mem_* registers live in the top module.

## Test plan
- Reset: hold resetn low with all req high → every gnt, rvalid and mem_en is 0. After release, cpu_req alone at addr 0x005 gives cpu_gnt=1 at T and mem_en=1 with mem_addr=0x005 at T+1. With memory data 0xAB, cpu_rvalid=1 and cpu_rdata=0xAB at T+3, and dbg_rvalid stays 0.
- Priority and round-robin: ld_req, cpu_req and dbg_req all held for 5 cycles → loader granted every cycle. Then drop ld_req → grants alternate cpu, dbg, cpu, dbg, starting with cpu.
- Lock with outstanding reads: 2 cpu reads accepted at T and T+1, ld_lock at T+2 → DRAIN. Both cpu_rvalid pulses arrive, then locked=1. No cpu_gnt is issued while locked even with cpu_req held.
- Loader burst: in LOCKED, write 0x2B to addresses 0..3 back-to-back → 4 consecutive mem_en/mem_we cycles. Drop ld_lock → locked=0, then a dbg read of addr 2 returns 0x2B on dbg_rvalid.
- Abort and reset: ld_lock pulsed for 1 cycle during DRAIN → state returns to NORMAL without locked ever rising. Assert resetn low with a read in flight → no rvalid appears after reset release.
